// File: rtl/vadd_seq_pkg.sv
// ---------------------------------------------------------------------------
// vadd_seq_pkg
// Shared types and helpers for the vector add issue sequencer.
//   state_e    : sequencer FSM states
//   SEW_*      : element width codes
//   CMP_BIT    : opsel bit that marks a compare (mask-producing) op
//   epw()      : elements per 64-bit word for a given SEW code
//   tail_be()  : byte-enable of the final chunk of a command
// ---------------------------------------------------------------------------
package vadd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] SEW_8  = 2'd0;
    localparam logic [1:0] SEW_16 = 2'd1;
    localparam logic [1:0] SEW_32 = 2'd2;
    localparam logic [1:0] SEW_64 = 2'd3;

    // Operand words carry 8 byte lanes.
    localparam int LANE_BYTES = 8;
    localparam int CMP_BIT    = 8;

    function automatic logic [3:0] epw(input logic [1:0] sew);
        return 4'd8 >> sew;
    endfunction

    // Tail element count is ((vl-1) mod EPW) + 1; EPW is a power of two no
    // larger than 8, so only the low three bits of vl matter.
    function automatic logic [7:0] tail_be(input logic [2:0] vl_lo,
                                           input logic [1:0] sew);
        logic [2:0] vm1;
        logic [3:0] tail_elems;
        logic [3:0] tail_bytes;
        vm1        = vl_lo - 3'd1;
        tail_elems = ({1'b0, vm1} & (epw(sew) - 4'd1)) + 4'd1;
        tail_bytes = tail_elems << sew;
        return 8'hFF >> (4'd8 - tail_bytes);
    endfunction

endpackage

// File: rtl/vadd_tag_pipe.sv
// ---------------------------------------------------------------------------
// vadd_tag_pipe
// Fixed-latency shift register of valid-tagged words. Every cycle the
// contents advance one stage; the head is stage DEPTH-1. Invalid entries
// carry zero data so the head data is clean whenever the head is empty.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears all stages)
//   i_valid   : push a tag this cycle
//   i_data    : tag payload
//   o_valid   : head stage holds a tag
//   o_data    : head stage payload
// DEPTH must be at least 2.
// ---------------------------------------------------------------------------
module vadd_tag_pipe #(
    parameter int DEPTH = 5,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_valid   <= {r_valid[DEPTH-2:0], i_valid};
            r_data[0] <= i_valid ? i_data : '0;
            for (int i = 1; i < DEPTH; i++) begin
                r_data[i] <= r_data[i-1];
            end
        end
    end

    assign o_valid = r_valid[DEPTH-1];
    assign o_data  = r_data[DEPTH-1];

endmodule

// File: rtl/vadd_issue_seq.sv
// ---------------------------------------------------------------------------
// vadd_issue_seq
// Issue sequencer for the vector add/min/max/compare ALU. Takes one command
// (vl, sew, opsel, addr), splits it into 64-bit chunks, forwards one operand
// pair per handshake to the ALU with incrementing destination addresses, and
// tags each chunk so writeback sees the byte-enable and last flag aligned
// with the ALU result.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   cmd_*                    : command handshake and fields
//   op_valid/op_ready/op_vec*: operand stream
//   alu_*                    : registered ALU drive
//   alu_out_valid            : ALU result valid (from ALU)
//   wb_be, wb_last           : tag of the current result (combinational)
//   done, busy, err          : status
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready high
// ST_ISSUE | accepting operand pairs, one chunk per handshake
// ST_DRAIN | all chunks issued, waiting for the last tagged result
// ST_DONE  | done pulse (vl==0 commands spend two cycles here)
// ---------------------------------------------------------------------------
module vadd_issue_seq
    import vadd_seq_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 32,
    parameter int SEW_WIDTH   = 2,
    parameter int OPSEL_WIDTH = 9,
    parameter int VL_WIDTH    = 11,
    parameter int ALU_LAT     = 4
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [VL_WIDTH-1:0]     cmd_vl,
    input  logic [SEW_WIDTH-1:0]    cmd_sew,
    input  logic [OPSEL_WIDTH-1:0]  cmd_opsel,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,

    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [DATA_WIDTH-1:0]   op_vec0,
    input  logic [DATA_WIDTH-1:0]   op_vec1,

    output logic                    alu_valid,
    output logic [DATA_WIDTH-1:0]   alu_vec0,
    output logic [DATA_WIDTH-1:0]   alu_vec1,
    output logic [SEW_WIDTH-1:0]    alu_sew,
    output logic [OPSEL_WIDTH-1:0]  alu_opsel,
    output logic                    alu_carry,
    output logic [ADDR_WIDTH-1:0]   alu_addr,

    input  logic                    alu_out_valid,
    output logic [DATA_WIDTH/8-1:0] wb_be,
    output logic                    wb_last,

    output logic                    done,
    output logic                    busy,
    output logic                    err
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int TAG_W = BE_W + 1;
    localparam int VLP1  = VL_WIDTH + 1;

    state_e                 r_state;
    logic [VL_WIDTH-1:0]    r_rem;
    logic [ADDR_WIDTH-1:0]  r_addr;
    logic [SEW_WIDTH-1:0]   r_sew;
    logic [OPSEL_WIDTH-1:0] r_opsel;
    logic [BE_W-1:0]        r_tail_be;
    logic                   r_zero;
    logic                   r_done;
    logic                   r_err;

    logic                   r_alu_valid;
    logic [DATA_WIDTH-1:0]  r_alu_vec0;
    logic [DATA_WIDTH-1:0]  r_alu_vec1;
    logic [SEW_WIDTH-1:0]   r_alu_sew;
    logic [OPSEL_WIDTH-1:0] r_alu_opsel;
    logic [ADDR_WIDTH-1:0]  r_alu_addr;

    logic                   w_issue;
    logic                   w_last_chunk;
    logic [BE_W-1:0]        w_tag_be;
    logic [VLP1-1:0]        w_vl_round;
    logic [VL_WIDTH-1:0]    w_chunks;
    logic                   w_head_valid;
    logic [TAG_W-1:0]       w_head_data;
    logic                   w_head_last;
    logic [BE_W-1:0]        w_head_be;

    assign w_issue      = (r_state == ST_ISSUE) && op_valid;
    assign w_last_chunk = (r_rem == VL_WIDTH'(1));

    // Compare ops write a mask into the low byte only, regardless of chunk.
    assign w_tag_be = r_opsel[CMP_BIT] ? BE_W'(1)
                    : (w_last_chunk ? r_tail_be : '1);

    // N = ceil(vl / EPW) with EPW = 2^(3-sew).
    assign w_vl_round = {1'b0, cmd_vl} + VLP1'(epw(cmd_sew) - 4'd1);
    assign w_chunks   = VL_WIDTH'(w_vl_round >> (2'd3 - cmd_sew));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_addr      <= '0;
            r_sew       <= '0;
            r_opsel     <= '0;
            r_tail_be   <= '0;
            r_zero      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_alu_valid <= 1'b0;
            r_alu_vec0  <= '0;
            r_alu_vec1  <= '0;
            r_alu_sew   <= '0;
            r_alu_opsel <= '0;
            r_alu_addr  <= '0;
        end else begin
            r_done      <= 1'b0;
            r_alu_valid <= w_issue;

            if (w_issue) begin
                r_alu_vec0  <= op_vec0;
                r_alu_vec1  <= op_vec1;
                r_alu_sew   <= r_sew;
                r_alu_opsel <= r_opsel;
                r_alu_addr  <= r_addr;
                r_addr      <= r_addr + ADDR_WIDTH'(1);
                r_rem       <= r_rem - VL_WIDTH'(1);
            end

            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_addr    <= cmd_addr;
                        r_sew     <= cmd_sew;
                        r_opsel   <= cmd_opsel;
                        r_tail_be <= BE_W'(tail_be(cmd_vl[2:0], cmd_sew));
                        if (cmd_vl == '0) begin
                            r_zero  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_rem   <= w_chunks;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (w_issue && w_last_chunk) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (alu_out_valid && w_head_valid && w_head_last) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // An empty command has no result to key off, so it
                    // spends one extra cycle here to raise its pulse.
                    if (r_zero) begin
                        r_zero <= 1'b0;
                        r_done <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase

            // Any disagreement between the tag head and the ALU is sticky.
            if (alu_out_valid != w_head_valid) begin
                r_err <= 1'b1;
            end
        end
    end

    // Stage count ALU_LAT+1 puts the head on the same cycle as the result:
    // one cycle for the registered ALU drive, ALU_LAT inside the ALU.
    vadd_tag_pipe #(
        .DEPTH (ALU_LAT + 1),
        .WIDTH (TAG_W)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_issue),
        .i_data  ({w_tag_be, w_last_chunk}),
        .o_valid (w_head_valid),
        .o_data  (w_head_data)
    );

    assign w_head_be   = w_head_data[TAG_W-1:1];
    assign w_head_last = w_head_data[0];

    assign wb_be   = alu_out_valid ? w_head_be : '0;
    assign wb_last = alu_out_valid && w_head_last;

    assign cmd_ready = (r_state == ST_IDLE);
    assign op_ready  = (r_state == ST_ISSUE);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;

    assign alu_valid = r_alu_valid;
    assign alu_vec0  = r_alu_vec0;
    assign alu_vec1  = r_alu_vec1;
    assign alu_sew   = r_alu_sew;
    assign alu_opsel = r_alu_opsel;
    assign alu_addr  = r_alu_addr;
    assign alu_carry = 1'b0;

endmodule

// File: tb/tb_vadd_issue_seq.sv
module tb_vadd_issue_seq;

    localparam int ALU_LAT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [10:0] cmd_vl;
    logic [1:0]  cmd_sew;
    logic [8:0]  cmd_opsel;
    logic [31:0] cmd_addr;
    logic        op_valid;
    logic        op_ready;
    logic [63:0] op_vec0;
    logic [63:0] op_vec1;
    logic        alu_valid;
    logic [63:0] alu_vec0;
    logic [63:0] alu_vec1;
    logic [1:0]  alu_sew;
    logic [8:0]  alu_opsel;
    logic        alu_carry;
    logic [31:0] alu_addr;
    logic        alu_out_valid;
    logic [7:0]  wb_be;
    logic        wb_last;
    logic        done;
    logic        busy;
    logic        err;

    // Simple ALU stand-in: result valid ALU_LAT cycles after sampling alu_valid.
    logic [ALU_LAT-1:0] alu_pipe;
    logic               inject;

    int n_vec = 0;
    int n_err = 0;

    // What the ALU drive outputs should currently hold.
    logic [31:0] hold_addr;
    logic [63:0] hold_v0;
    logic [63:0] hold_v1;
    logic [1:0]  hold_sew;
    logic [8:0]  hold_opsel;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) alu_pipe <= '0;
        else     alu_pipe <= {alu_pipe[ALU_LAT-2:0], alu_valid};
    end

    assign alu_out_valid = alu_pipe[ALU_LAT-1] | inject;

    vadd_issue_seq dut (
        .clk           (clk),
        .rst           (rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_vl        (cmd_vl),
        .cmd_sew       (cmd_sew),
        .cmd_opsel     (cmd_opsel),
        .cmd_addr      (cmd_addr),
        .op_valid      (op_valid),
        .op_ready      (op_ready),
        .op_vec0       (op_vec0),
        .op_vec1       (op_vec1),
        .alu_valid     (alu_valid),
        .alu_vec0      (alu_vec0),
        .alu_vec1      (alu_vec1),
        .alu_sew       (alu_sew),
        .alu_opsel     (alu_opsel),
        .alu_carry     (alu_carry),
        .alu_addr      (alu_addr),
        .alu_out_valid (alu_out_valid),
        .wb_be         (wb_be),
        .wb_last       (wb_last),
        .done          (done),
        .busy          (busy),
        .err           (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_op_ready",  op_ready,  0);
        chk("rst_alu_valid", alu_valid, 0);
        chk("rst_alu_vec0",  alu_vec0,  0);
        chk("rst_alu_vec1",  alu_vec1,  0);
        chk("rst_alu_sew",   alu_sew,   0);
        chk("rst_alu_opsel", alu_opsel, 0);
        chk("rst_alu_carry", alu_carry, 0);
        chk("rst_alu_addr",  alu_addr,  0);
        chk("rst_wb_be",     wb_be,     0);
        chk("rst_wb_last",   wb_last,   0);
        chk("rst_done",      done,      0);
        chk("rst_busy",      busy,      0);
        chk("rst_err",       err,       0);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic apply_reset(input int cycles);
        rst = 1'b1; cmd_valid = 1'b0; op_valid = 1'b0; inject = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        check_reset_vals();
        @(posedge clk); #1;
        rst = 1'b0;
        hold_addr = '0; hold_v0 = '0; hold_v1 = '0; hold_sew = '0; hold_opsel = '0;
    endtask

    // mode: 0 = op_valid held high, 1 = toggling, 2 = random
    task automatic run_cmd(input int vl, input int sew, input logic [8:0] opsel,
                           input logic [31:0] addr, input int mode);
        int  epw, n, t, issued, outs, cyc, exp_done, bytes;
        bit  hs, prev_hs, exp_rdy;
        logic [63:0] exp_be;
        epw      = 8 >> sew;
        n        = (vl + epw - 1) / epw;
        t        = (n > 0) ? vl - (n - 1) * epw : 0;
        exp_done = (n == 0) ? 2 : 1000000;

        cmd_valid = 1'b1; cmd_vl = 11'(vl); cmd_sew = 2'(sew);
        cmd_opsel = opsel; cmd_addr = addr;
        @(negedge clk);
        chk("cmd_ready_idle", cmd_ready, 1);
        chk("busy_idle", busy, 0);
        @(posedge clk); #1;
        // Scramble the fields: the command must have been latched.
        cmd_valid = 1'b0; cmd_vl = 11'($urandom); cmd_sew = 2'($urandom);
        cmd_opsel = 9'($urandom); cmd_addr = $urandom;

        issued = 0; outs = 0; prev_hs = 0; cyc = 1;
        while (cyc <= exp_done + 1 && cyc < 600) begin
            exp_rdy = (issued < n);
            case (mode)
                0:       op_valid = 1'b1;
                1:       op_valid = ((cyc % 2) == 1);
                default: op_valid = ($urandom_range(0, 3) != 0);
            endcase
            op_vec0 = {$urandom, $urandom};
            op_vec1 = {$urandom, $urandom};
            hs = op_valid && exp_rdy;
            @(negedge clk);
            chk("op_ready",  op_ready,  exp_rdy);
            chk("busy",      busy,      cyc <= exp_done);
            chk("cmd_ready", cmd_ready, cyc > exp_done);
            chk("done",      done,      cyc == exp_done);
            chk("alu_valid", alu_valid, prev_hs);
            chk("alu_addr",  alu_addr,  hold_addr);
            chk("alu_vec0",  alu_vec0,  hold_v0);
            chk("alu_vec1",  alu_vec1,  hold_v1);
            chk("alu_sew",   alu_sew,   hold_sew);
            chk("alu_opsel", alu_opsel, hold_opsel);
            chk("alu_carry", alu_carry, 0);
            chk("err",       err,       0);
            if (alu_out_valid) begin
                bytes  = opsel[8] ? 1 : ((outs == n - 1) ? (t << sew) : 8);
                exp_be = (64'd1 << bytes) - 64'd1;
                chk("wb_be",   wb_be,   exp_be);
                chk("wb_last", wb_last, outs == n - 1);
                outs++;
            end else begin
                chk("wb_be_idle",   wb_be,   0);
                chk("wb_last_idle", wb_last, 0);
            end
            if (hs) begin
                hold_addr  = addr + 32'(issued);
                hold_v0    = op_vec0;
                hold_v1    = op_vec1;
                hold_sew   = 2'(sew);
                hold_opsel = opsel;
                issued++;
                if (issued == n) exp_done = cyc + ALU_LAT + 2;
            end
            prev_hs = hs;
            @(posedge clk); #1;
            cyc++;
        end
        op_valid = 1'b0;
        chk("result_count", outs, n);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_vl = '0; cmd_sew = '0; cmd_opsel = '0;
        cmd_addr = '0; op_valid = 1'b0; op_vec0 = '0; op_vec1 = '0; inject = 1'b0;
        @(posedge clk); #1;
        apply_reset(2);

        run_cmd(8,  0, 9'h000, 32'h100, 0);
        run_cmd(5,  1, 9'h001, 32'h100, 0);
        run_cmd(3,  3, 9'h002, 32'h200, 1);
        run_cmd(0,  2, 9'h003, 32'h240, 0);
        run_cmd(16, 0, 9'h100, 32'h300, 0);

        // Reset while issuing: one chunk out of three already sent.
        cmd_valid = 1'b1; cmd_vl = 11'd3; cmd_sew = 2'd3;
        cmd_opsel = 9'h004; cmd_addr = 32'h400;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        op_valid = 1'b1; op_vec0 = {$urandom, $urandom}; op_vec1 = {$urandom, $urandom};
        @(posedge clk); #1;
        op_valid = 1'b0;
        @(negedge clk);
        chk("mid_alu_valid", alu_valid, 1);
        chk("mid_busy", busy, 1);
        @(posedge clk); #1;
        apply_reset(1);
        run_cmd(3, 3, 9'h005, 32'h500, 0);

        for (int k = 0; k < 6; k++) begin
            run_cmd($urandom_range(1, 40), $urandom_range(0, 3), 9'($urandom),
                    (k == 2) ? 32'hFFFF_FFFE : $urandom, 2);
        end

        // Result with no tag while idle.
        inject = 1'b1;
        @(negedge clk);
        chk("inj_wb_be", wb_be, 0);
        chk("inj_wb_last", wb_last, 0);
        chk("inj_err_before", err, 0);
        @(posedge clk); #1;
        inject = 1'b0;
        @(negedge clk);
        chk("inj_err_set", err, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("inj_err_sticky", err, 1);
        @(posedge clk); #1;
        apply_reset(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
